// File: rtl/operand_loader.sv
// Two-operand entry for a nibble adder: debounced load/clear buttons step an A/B/SHOW FSM.
// Raw button rise to load_pulse is 2 + DEBOUNCE_CYCLES + 1 cycles; operands update the cycle after.

module operand_loader_btn #(
  parameter int DEBOUNCE_CYCLES = 1250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;
  logic [1:0]    r_warm;
  logic          r_armed;
  logic          r_press;

  // r_armed stays low until a released level is seen after reset, so a button
  // held through reset release cannot produce a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_warm    <= 2'b00;
      r_armed   <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_warm    <= {r_warm[0], 1'b1};
      r_level_d <= r_level;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_warm[1] && !r_sync2 && !r_level) begin
        r_armed <= 1'b1;
      end
      r_press <= r_level & ~r_level_d & r_armed;
    end
  end

  assign o_press = r_press;

endmodule

module operand_loader #(
  parameter int DEBOUNCE_CYCLES = 1250000
) (
  input  logic       sysclk_125mhz,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       btn_load,
  input  logic       btn_clear,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic       operands_valid,
  output logic [1:0] state,
  output logic       load_pulse
);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    SHOW   = 2'b10
  } state_t;

  logic       w_ld_press;
  logic       w_clr_press;
  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_op_a;
  logic [3:0] r_op_b;
  logic [3:0] w_op_a_nxt;
  logic [3:0] w_op_b_nxt;
  logic       r_valid;

  operand_loader_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_load (
    .clk     (sysclk_125mhz),
    .rst_n   (rst),
    .i_btn   (btn_load),
    .o_press (w_ld_press)
  );

  operand_loader_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clear (
    .clk     (sysclk_125mhz),
    .rst_n   (rst),
    .i_btn   (btn_clear),
    .o_press (w_clr_press)
  );

  always_ff @(posedge sysclk_125mhz or negedge rst) begin
    if (!rst) begin
      r_state <= LOAD_A;
      r_op_a  <= 4'h0;
      r_op_b  <= 4'h0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op_a  <= w_op_a_nxt;
      r_op_b  <= w_op_b_nxt;
      r_valid <= (w_state_nxt == SHOW);
    end
  end

  // Clear outranks a coincident load; the encoding 11 falls back to LOAD_A.
  always_comb begin
    w_state_nxt = r_state;
    w_op_a_nxt  = r_op_a;
    w_op_b_nxt  = r_op_b;
    if (w_clr_press) begin
      w_state_nxt = LOAD_A;
      w_op_a_nxt  = 4'h0;
      w_op_b_nxt  = 4'h0;
    end else begin
      case (r_state)
        LOAD_A: begin
          if (w_ld_press) begin
            w_op_a_nxt  = sw;
            w_state_nxt = LOAD_B;
          end
        end
        LOAD_B: begin
          if (w_ld_press) begin
            w_op_b_nxt  = sw;
            w_state_nxt = SHOW;
          end
        end
        SHOW: begin
          if (w_ld_press) begin
            w_op_a_nxt  = sw;
            w_state_nxt = LOAD_B;
          end
        end
        default: w_state_nxt = LOAD_A;
      endcase
    end
  end

  assign op_a           = r_op_a;
  assign op_b           = r_op_b;
  assign operands_valid = r_valid;
  assign state          = r_state;
  assign load_pulse     = w_ld_press;

endmodule

// File: tb/tb_operand_loader.sv
// Randomized and directed bench for operand_loader with a short debounce window.
module tb_operand_loader;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sw = 4'h0;
  logic       btn_load = 1'b0;
  logic       btn_clear = 1'b0;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       operands_valid;
  logic [1:0] state;
  logic       load_pulse;

  int checks = 0;
  int errors = 0;
  int npulse = 0;

  operand_loader #(.DEBOUNCE_CYCLES(N)) dut (
    .sysclk_125mhz  (clk),
    .rst            (rst),
    .sw             (sw),
    .btn_load       (btn_load),
    .btn_clear      (btn_clear),
    .op_a           (op_a),
    .op_b           (op_b),
    .operands_valid (operands_valid),
    .state          (state),
    .load_pulse     (load_pulse)
  );

  always #5 clk = ~clk;

  // Reference: index 0 = load button, 1 = clear button.
  // mh holds raw samples, newest first; the debounced level flips once the
  // synchronized (two-cycle-late) samples disagree with it for N edges running.
  bit         mh [2][N+1];
  bit         mdeb [2];
  bit         mrose [2];
  bit         marmed [2];
  bit         mpulse [2];
  int         mage = 0;
  int         mst = 0;
  logic [3:0] ma = 4'h0;
  logic [3:0] mb = 4'h0;

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j <= N; j++) mh[b][j] = 1'b0;
      mdeb[b] = 1'b0; mrose[b] = 1'b0; marmed[b] = 1'b0; mpulse[b] = 1'b0;
    end
    mage = 0; mst = 0; ma = 4'h0; mb = 4'h0;
  endtask

  task automatic model_step();
    bit raw [2];
    bit np [2];
    bit diff;
    raw[0] = btn_load;
    raw[1] = btn_clear;
    if (mpulse[1]) begin
      ma = 4'h0; mb = 4'h0; mst = 0;
    end else if (mpulse[0]) begin
      if (mst == 0)      begin ma = sw; mst = 1; end
      else if (mst == 1) begin mb = sw; mst = 2; end
      else               begin ma = sw; mst = 1; end
    end
    for (int b = 0; b < 2; b++) begin
      np[b] = mrose[b] && marmed[b];
      if (mage >= 2 && !mh[b][1] && !mdeb[b]) marmed[b] = 1'b1;
      diff = 1'b1;
      for (int j = 1; j <= N; j++) if (mh[b][j] == mdeb[b]) diff = 1'b0;
      mrose[b] = diff && !mdeb[b];
      if (diff) mdeb[b] = !mdeb[b];
      for (int j = N; j >= 1; j--) mh[b][j] = mh[b][j-1];
      mh[b][0] = raw[b];
      mpulse[b] = np[b];
    end
    if (mage < 100) mage++;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (load_pulse === 1'b1) npulse++;
    if (!rst) begin
      chk("rst_op_a", 32'(op_a), 0);
      chk("rst_op_b", 32'(op_b), 0);
      chk("rst_valid", 32'(operands_valid), 0);
      chk("rst_state", 32'(state), 0);
      chk("rst_pulse", 32'(load_pulse), 0);
    end else begin
      chk("op_a", 32'(op_a), 32'(ma));
      chk("op_b", 32'(op_b), 32'(mb));
      chk("operands_valid", 32'(operands_valid), 32'(mst == 2));
      chk("state", 32'(state), 32'(mst));
      chk("load_pulse", 32'(load_pulse), 32'(mpulse[0]));
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Clean press: measures raw-rise-to-pulse latency, holds, then releases.
  task automatic press(logic [3:0] v, int hold);
    int lat;
    lat = 0;
    sw = v;
    btn_load = 1'b1;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (load_pulse === 1'b1) lat = i;
    end
    #1;
    chk("press_latency", 32'(lat), 32'(2 + N + 1));
    tick(hold);
    btn_load = 1'b0;
    tick(12);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int tl;
    int tc;
    tick(3);
    chk("reset_op_a", 32'(op_a), 0);
    chk("reset_state", 32'(state), 0);
    rst = 1'b1;
    tick(5);

    // Bounce shorter than the window never settles.
    base = npulse;
    for (int i = 0; i < 5; i++) begin
      btn_load = 1'b1; tick(2);
      btn_load = 1'b0; tick(2);
    end
    tick(10);
    chk("bounce_pulses", 32'(npulse - base), 0);
    chk("bounce_state", 32'(state), 0);

    base = npulse;
    press(4'h5, 3);
    press(4'h9, 3);
    chk("two_loads_pulses", 32'(npulse - base), 2);
    chk("show_op_a", 32'(op_a), 32'h5);
    chk("show_op_b", 32'(op_b), 32'h9);
    chk("show_valid", 32'(operands_valid), 1);
    chk("show_state", 32'(state), 32'h2);

    press(4'hF, 3);
    chk("reload_op_a", 32'(op_a), 32'hF);
    chk("reload_op_b", 32'(op_b), 32'h9);
    chk("reload_state", 32'(state), 32'h1);
    chk("reload_valid", 32'(operands_valid), 0);

    // Clear and load settle together in LOAD_B: clear wins, load_pulse still fires.
    base = npulse;
    sw = 4'h3;
    btn_load = 1'b1; btn_clear = 1'b1;
    tick(12);
    btn_load = 1'b0; btn_clear = 1'b0;
    tick(12);
    chk("clr_ld_pulse", 32'(npulse - base), 1);
    chk("clr_ld_op_a", 32'(op_a), 0);
    chk("clr_ld_op_b", 32'(op_b), 0);
    chk("clr_ld_state", 32'(state), 0);

    base = npulse;
    sw = 4'h6;
    btn_load = 1'b1;
    tick(50);
    btn_load = 1'b0;
    tick(12);
    chk("held_pulses", 32'(npulse - base), 1);
    chk("held_op_a", 32'(op_a), 32'h6);
    chk("held_state", 32'(state), 32'h1);

    // Reset mid-debounce, between clock edges, with the button kept held.
    sw = 4'h2;
    btn_load = 1'b1;
    tick(4);
    #1;
    rst = 1'b0;
    #1;
    chk("async_op_a", 32'(op_a), 0);
    chk("async_state", 32'(state), 0);
    chk("async_pulse", 32'(load_pulse), 0);
    tick(3);
    rst = 1'b1;
    base = npulse;
    tick(30);
    chk("held_thru_reset_pulses", 32'(npulse - base), 0);
    chk("held_thru_reset_state", 32'(state), 0);
    btn_load = 1'b0;
    tick(12);
    press(4'h7, 2);
    chk("after_reset_op_a", 32'(op_a), 32'h7);

    // Random button activity with occasional resets.
    tl = 1; tc = 1;
    for (int c = 0; c < 2000; c++) begin
      sw = 4'($urandom);
      if (--tl == 0) begin
        btn_load = ~btn_load;
        tl = $urandom_range(1, 9);
      end
      if (--tc == 0) begin
        btn_clear = ~btn_clear;
        tc = (btn_clear) ? $urandom_range(1, 8) : $urandom_range(6, 40);
      end
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
      end
      tick(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
